// File: rtl/beam_threshold_loader_if.sv
// Write/commit command stream from the register bank to the threshold loader.
// The master side drives the requests and the slave side answers with the readies.
interface beam_threshold_loader_if #(
  parameter int THRESH_BITS   = 18,
  parameter int BEAM_IDX_BITS = 6
);
  logic                     wr_valid_i;
  logic                     wr_ready_o;
  logic [BEAM_IDX_BITS-1:0] wr_beam_i;
  logic                     wr_all_i;
  logic [THRESH_BITS-1:0]   wr_thresh_i;
  logic                     commit_valid_i;
  logic                     commit_ready_o;

  modport master (
    output wr_valid_i, wr_beam_i, wr_all_i, wr_thresh_i, commit_valid_i,
    input  wr_ready_o, commit_ready_o
  );

  modport slave (
    input  wr_valid_i, wr_beam_i, wr_all_i, wr_thresh_i, commit_valid_i,
    output wr_ready_o, commit_ready_o
  );
endinterface

// File: rtl/beam_threshold_loader.sv
// Sequences per-beam threshold loads and the global update strobe for the beamformer array.
// Guarantees at least one quiet cycle between the last load enable and the update pulse.
module beam_threshold_loader #(
  parameter int NBEAMS         = 46,
  parameter int THRESH_BITS    = 18,
  parameter int BEAM_IDX_BITS  = 6,
  parameter int UPDATE_HOLDOFF = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  beam_threshold_loader_if.slave cmd,
  output logic [THRESH_BITS-1:0] thresh_o,
  output logic [NBEAMS-1:0]      thresh_ce_o,
  output logic                   update_o,
  output logic                   busy_o,
  output logic                   dirty_o,
  output logic                   err_o,
  input  logic                   err_clr_i,
  output logic [15:0]            update_count_o
);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, UPD, HOLD} state_t;

  localparam int HOLD_W = (UPDATE_HOLDOFF > 1) ? $clog2(UPDATE_HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(UPDATE_HOLDOFF - 1);
  localparam logic [BEAM_IDX_BITS:0] NBEAMS_W = (BEAM_IDX_BITS + 1)'(NBEAMS);

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                wr_fire;
  logic                commit_fire;
  logic                beam_ok;
  logic                bad_beam;
  logic [NBEAMS-1:0]   beam_onehot;

  assign cmd.wr_ready_o     = (state == IDLE);
  assign cmd.commit_ready_o = (state == IDLE) && !cmd.wr_valid_i;

  assign wr_fire     = (state == IDLE) && cmd.wr_valid_i;
  assign commit_fire = (state == IDLE) && !cmd.wr_valid_i && cmd.commit_valid_i;
  assign beam_ok     = {1'b0, cmd.wr_beam_i} < NBEAMS_W;
  assign bad_beam    = wr_fire && !cmd.wr_all_i && !beam_ok;

  always_comb begin
    beam_onehot = '0;
    for (int unsigned i = 0; i < NBEAMS; i++) begin
      if (cmd.wr_beam_i == BEAM_IDX_BITS'(i)) beam_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      thresh_o       <= '0;
      thresh_ce_o    <= '0;
      update_o       <= 1'b0;
      busy_o         <= 1'b0;
      dirty_o        <= 1'b0;
      err_o          <= 1'b0;
      update_count_o <= '0;
    end else begin
      // Strobes default low so every enable/update lasts exactly one cycle.
      thresh_ce_o <= '0;
      update_o    <= 1'b0;
      err_o       <= bad_beam | (err_o & ~err_clr_i);

      unique case (state)
        IDLE: begin
          if (wr_fire) begin
            state  <= LOAD;
            busy_o <= 1'b1;
            if (cmd.wr_all_i || beam_ok) begin
              thresh_o    <= cmd.wr_thresh_i;
              thresh_ce_o <= cmd.wr_all_i ? '1 : beam_onehot;
              dirty_o     <= 1'b1;
            end
          end else if (commit_fire) begin
            busy_o <= 1'b1;
            state  <= dirty_o ? GAP : LOAD;
          end
        end
        LOAD: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        GAP: begin
          state    <= UPD;
          update_o <= 1'b1;
        end
        UPD: begin
          state    <= HOLD;
          hold_cnt <= HOLD_LAST;
          dirty_o  <= 1'b0;
          if (update_count_o != '1) update_count_o <= update_count_o + 16'd1;
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beam_threshold_loader.sv
// Self-checking bench for beam_threshold_loader: directed vectors, corner sequences,
// and randomized traffic against a cycle-timeline reference model.
module tb_beam_threshold_loader;
  localparam int NB  = 46;
  localparam int TB  = 18;
  localparam int BIB = 6;
  localparam int H   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          err_clr = 1'b0;
  logic [TB-1:0] thresh;
  logic [NB-1:0] ce;
  logic          upd, busy, dirty, err;
  logic [15:0]   cnt;

  int errors = 0;
  int checks = 0;

  beam_threshold_loader_if #(.THRESH_BITS(TB), .BEAM_IDX_BITS(BIB)) bus ();

  beam_threshold_loader #(
    .NBEAMS(NB), .THRESH_BITS(TB), .BEAM_IDX_BITS(BIB), .UPDATE_HOLDOFF(H)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cmd(bus),
    .thresh_o(thresh), .thresh_ce_o(ce), .update_o(upd), .busy_o(busy),
    .dirty_o(dirty), .err_o(err), .err_clr_i(err_clr), .update_count_o(cnt)
  );

  always #5 clk = ~clk;

  // Reference model: outputs derived from absolute cycle numbers of accepted commands.
  int            cyc;
  int            idle_at;
  int            update_at;
  logic [TB-1:0] m_thresh;
  logic [NB-1:0] m_ce;
  logic          m_upd, m_dirty, m_err, m_busy;
  logic [15:0]   m_cnt;
  logic [NB-1:0] last_ce;

  typedef struct {
    logic          all;
    logic [BIB-1:0] beam;
    logic [TB-1:0] data;
    logic [TB-1:0] exp_thresh;
    logic [NB-1:0] exp_ce;
    logic          exp_err;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.wr_valid_i     = 1'b0;
    bus.wr_all_i       = 1'b0;
    bus.wr_beam_i      = '0;
    bus.wr_thresh_i    = '0;
    bus.commit_valid_i = 1'b0;
    err_clr            = 1'b0;
  endtask

  task automatic model_reset();
    cyc = 0; idle_at = 0; update_at = -100;
    m_thresh = '0; m_ce = '0; m_upd = 0; m_dirty = 0; m_err = 0; m_busy = 0;
    m_cnt = '0; last_ce = '0;
  endtask

  // Called at a falling edge with inputs already applied; ends at the next falling edge.
  task automatic step();
    logic idle, newerr;
    int n;
    n = cyc;
    idle = (n >= idle_at);
    #1;
    chk("wr_ready", bus.wr_ready_o, idle);
    chk("commit_ready", bus.commit_ready_o, idle && !bus.wr_valid_i);
    @(posedge clk);
    m_ce = '0;
    m_upd = (n + 1 == update_at);
    if (n + 1 == update_at + 1) begin
      m_dirty = 1'b0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    newerr = idle && bus.wr_valid_i && !bus.wr_all_i && (int'(bus.wr_beam_i) >= NB);
    m_err = newerr || (m_err && !err_clr);
    if (idle && bus.wr_valid_i) begin
      if (bus.wr_all_i || int'(bus.wr_beam_i) < NB) begin
        m_thresh = bus.wr_thresh_i;
        if (bus.wr_all_i) m_ce = '1;
        else m_ce[int'(bus.wr_beam_i)] = 1'b1;
        m_dirty = 1'b1;
      end
      idle_at = n + 2;
    end else if (idle && bus.commit_valid_i) begin
      if (m_dirty) begin
        update_at = n + 2;
        idle_at   = n + 3 + H;
      end else begin
        idle_at = n + 2;
      end
    end
    m_busy = (n + 1) < idle_at;
    cyc++;
    @(negedge clk);
    chk("thresh", thresh, m_thresh);
    chk("thresh_ce", ce, m_ce);
    chk("update", upd, m_upd);
    chk("dirty", dirty, m_dirty);
    chk("err", err, m_err);
    chk("update_count", cnt, m_cnt);
    chk("busy", busy, m_busy);
    chk("inv_ce_with_update", upd && (|ce), 1'b0);
    chk("inv_ce_consecutive", (|last_ce) && (|ce), 1'b0);
    chk("inv_ce_before_update", upd && (|last_ce), 1'b0);
    last_ce = ce;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_thresh", thresh, 0);
    chk("rst_ce", ce, 0);
    chk("rst_update", upd, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_err", err, 0);
    chk("rst_count", cnt, 0);
    chk("rst_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_update_held", upd, 0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{all: 1'b0, beam: 6'd5,  data: 18'h1A2B3, exp_thresh: 18'h1A2B3,
                exp_ce: 46'h20,             exp_err: 1'b0};
    vecs[1] = '{all: 1'b1, beam: 6'd63, data: 18'h00400, exp_thresh: 18'h00400,
                exp_ce: 46'h3FFF_FFFF_FFFF, exp_err: 1'b0};
    vecs[2] = '{all: 1'b0, beam: 6'd50, data: 18'h3FFFF, exp_thresh: 18'h00400,
                exp_ce: 46'h0,              exp_err: 1'b1};
    vecs[3] = '{all: 1'b0, beam: 6'd45, data: 18'h12345, exp_thresh: 18'h12345,
                exp_ce: 46'h2000_0000_0000, exp_err: 1'b1};
    vecs[4] = '{all: 1'b0, beam: 6'd0,  data: 18'h00001, exp_thresh: 18'h00001,
                exp_ce: 46'h1,              exp_err: 1'b1};

    set_idle();
    #1;
    do_reset();
    repeat (3) step();

    // Directed write vectors.
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid_i  = 1'b1;
      bus.wr_all_i    = vecs[i].all;
      bus.wr_beam_i   = vecs[i].beam;
      bus.wr_thresh_i = vecs[i].data;
      step();
      chk("vec_thresh", thresh, vecs[i].exp_thresh);
      chk("vec_ce", ce, vecs[i].exp_ce);
      chk("vec_err", err, vecs[i].exp_err);
      chk("vec_dirty", dirty, 1'b1);
      set_idle();
      step();
      chk("vec_ce_cleared", ce, 0);
      chk("vec_ready_back", bus.wr_ready_o, 1'b1);
    end

    // Error clear, then clear colliding with a new error.
    err_clr = 1'b1;
    step();
    chk("err_cleared", err, 0);
    err_clr = 1'b1;
    bus.wr_valid_i = 1'b1;
    bus.wr_beam_i  = 6'd60;
    step();
    chk("err_priority", err, 1);
    set_idle();
    err_clr = 1'b1;
    step();
    chk("err_cleared2", err, 0);
    set_idle();

    // Commit timing: update two cycles after acceptance, holdoff before ready returns.
    bus.commit_valid_i = 1'b1;
    step();
    bus.commit_valid_i = 1'b0;
    for (int j = 1; j <= H + 4; j++) begin
      step();
      chk("commit_update_pulse", upd, j == 1);
      chk("commit_ready_timing", bus.commit_ready_o, (j + 1) >= (H + 3));
      if (j == 2) begin
        chk("commit_count", cnt, 16'd1);
        chk("commit_dirty_clr", dirty, 0);
      end
    end

    // Commit with nothing loaded: one busy cycle, no update, counter unchanged.
    bus.commit_valid_i = 1'b1;
    step();
    bus.commit_valid_i = 1'b0;
    chk("clean_commit_busy", busy, 1);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("clean_commit_no_update", upd, 0);
      chk("clean_commit_count", cnt, 16'd1);
      if (j == 1) chk("clean_commit_idle", busy, 0);
    end

    // Write and commit together: write first, commit two cycles later.
    for (int s = 1; s <= 10; s++) begin
      bus.wr_valid_i     = (s == 1);
      bus.wr_beam_i      = 6'd7;
      bus.wr_thresh_i    = 18'h2AAAA;
      bus.commit_valid_i = (s <= 3);
      step();
      chk("simul_update", upd, s == 4);
      chk("simul_ce", |ce, s == 1);
    end
    set_idle();
    repeat (2) step();

    // Reset while in GAP: no update may follow.
    bus.wr_valid_i = 1'b1;
    bus.wr_beam_i  = 6'd3;
    bus.wr_thresh_i = 18'h0BEEF;
    step();
    set_idle();
    step();
    bus.commit_valid_i = 1'b1;
    step();
    set_idle();
    chk("gap_busy", busy, 1);
    #2;
    do_reset();
    for (int j = 0; j < 8; j++) begin
      step();
      chk("post_reset_no_update", upd, 0);
    end

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      bus.wr_valid_i     = ($urandom_range(0, 2) == 0);
      bus.wr_all_i       = ($urandom_range(0, 7) == 0);
      bus.wr_beam_i      = BIB'($urandom_range(0, 63));
      bus.wr_thresh_i    = TB'($urandom);
      bus.commit_valid_i = ($urandom_range(0, 3) == 0);
      err_clr            = ($urandom_range(0, 15) == 0);
      step();
    end
    set_idle();
    repeat (H + 4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/beam_threshold_loader.md
Name: beam_threshold_loader

Overview:
- Drives the per-beam threshold programming interface of the beamforming trigger array: thresh value, per-beam clock enables, and the global update strobe.
- Converts a simple valid/ready write and commit command stream, fed from the control register space, into correctly sequenced single-cycle strobes.
- Guarantees that update never coincides with, or immediately follows, a threshold load.
- Sits between the register bank and the beam alignment/beamformer block, in the same clock domain.

Parameters:
- NBEAMS, 46: number of beams; width of thresh_ce_o.
- THRESH_BITS, 18: threshold width.
- BEAM_IDX_BITS, 6: width of the beam index; 2**BEAM_IDX_BITS >= NBEAMS.
- UPDATE_HOLDOFF, 4: busy cycles after the update_o pulse before the next command is accepted; minimum 1.

Ports:
- clk_i  in  1  trigger clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- wr_valid_i  in  1  threshold write request.
- wr_ready_o  out  1  write accepted when high with wr_valid_i.
- wr_beam_i  in  BEAM_IDX_BITS  target beam index.
- wr_all_i  in  1  broadcast to all beams; wr_beam_i is ignored.
- wr_thresh_i  in  THRESH_BITS  threshold value.
- commit_valid_i  in  1  request to apply loaded thresholds.
- commit_ready_o  out  1  commit accepted when high with commit_valid_i.
- thresh_o  out  THRESH_BITS  threshold to beamformers.
- thresh_ce_o  out  NBEAMS  per-beam load enables.
- update_o  out  1  global threshold update strobe.
- busy_o  out  1  FSM not in IDLE.
- dirty_o  out  1  loads issued since the last update.
- err_o  out  1  sticky flag: out-of-range beam index.
- err_clr_i  in  1  clears err_o.
- update_count_o  out  16  number of update_o pulses issued; saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - thresh_o=0, thresh_ce_o=0, update_o=0, dirty_o=0, err_o=0, update_count_o=0, busy_o=0.
  - A reset mid-sequence aborts the sequence; no further strobes are issued.
- All outputs are registered. Ready signals are combinational from state, plus wr_valid_i for commit.
- States: IDLE, LOAD, GAP, UPD, HOLD.
- wr_ready_o = (state==IDLE).
- commit_ready_o = (state==IDLE) && !wr_valid_i. On simultaneous requests the write wins and the commit waits.
- Write accepted at cycle N:
  - wr_all_i=1: thresh_o=wr_thresh_i and thresh_ce_o=all ones, during cycle N+1 only.
  - Otherwise, if wr_beam_i<NBEAMS: thresh_o=wr_thresh_i and thresh_ce_o=one-hot(wr_beam_i), during N+1 only.
  - Otherwise (index >= NBEAMS): no enable, thresh_o unchanged, dirty_o unchanged, err_o=1 from N+1.
  - State goes to LOAD for cycle N+1 (ready low), then IDLE at N+2. Maximum write rate is one per 2 cycles.
  - dirty_o=1 from N+1 on any valid load.
  - thresh_o holds its last value between writes.
- Commit accepted at cycle N with dirty_o=1:
  - GAP at N+1; all strobes low.
  - UPD at N+2: update_o=1 for exactly one cycle; dirty_o cleared at N+3; update_count_o increments at N+3 unless saturated.
  - HOLD for UPDATE_HOLDOFF cycles, then IDLE. Both readies stay low throughout.
- Commit accepted with dirty_o=0: no update_o. LOAD-equivalent single busy cycle, then IDLE; counter unchanged.
- Invariants:
  - update_o and any thresh_ce_o bit are never high in the same cycle.
  - At least one all-low cycle separates the last thresh_ce_o from update_o.
  - thresh_ce_o is never high for two consecutive cycles.
- err_clr_i clears err_o next cycle. A simultaneous new error takes priority, so err_o stays 1.
- busy_o=1 in every state except IDLE.

Test Plan:
- Reset release, then write beam 5 with 0x1A2B3 at cycle 10 -> cycle 11: thresh_o=0x1A2B3, thresh_ce_o=1<<5; cycle 12: all enables 0 and wr_ready_o=1; dirty_o=1.
- Commit at cycle 20 after that write -> update_o=1 only in cycle 22; update_count_o=1 and dirty_o=0 at 23; commit_ready_o low cycles 21..(22+UPDATE_HOLDOFF), high again at cycle 23+UPDATE_HOLDOFF (=27 with default).
- Broadcast write 0x00400 with wr_beam_i=63 and wr_all_i=1 -> thresh_ce_o all 46 ones for one cycle; err_o stays 0.
- Write beam 50 (NBEAMS=46) -> no enable, thresh_o unchanged, err_o=1. err_clr_i pulse -> err_o=0 next cycle.
- Write and commit valid in the same IDLE cycle -> write accepted first; commit accepted 2 cycles later; update_o at commit acceptance +2; never overlapping thresh_ce_o.
- Assert rst_n_i low during GAP -> all outputs 0 immediately; no update_o after release. Commit with dirty_o=0 -> no update_o and counter unchanged.
